// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU data-bus blocks: arbiter states,
// default bus widths and master index constants.
package mcu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic MST_CPU    = 1'b0;
    localparam logic MST_LOADER = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin select: on a tie the master that was
// not granted last wins; a lone request is always granted.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic grant
);

    assign valid = req0 | req1;

    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last;
        end else begin
            grant = req1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU data port (master 0) and
// the loader/DMA port (master 1) with round-robin priority.
//
// Handshake: a master raises req with we/addr/wdata and holds them until the
// cycle in which its ack pulses; the cycle after ack starts a new request.
// A master whose ack is high this cycle is masked out of arbitration so a
// held req is not taken for a second transfer.
module ram_arbiter
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

    arb_state_t        state;
    logic [1:0]        wait_cnt;
    logic              last_grant;
    logic              cur_grant;

    logic              pick_valid;
    logic              pick;
    logic              live_req0;
    logic              live_req1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign live_req0 = req0 & ~ack0;
    assign live_req1 = req1 & ~ack1;

    rr_pick2 u_pick (
        .req0  (live_req0),
        .req1  (live_req1),
        .last  (last_grant),
        .valid (pick_valid),
        .grant (pick)
    );

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (pick == MST_LOADER) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            last_grant <= MST_LOADER;
            cur_grant  <= MST_CPU;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur_grant  <= pick;
                        last_grant <= pick;
                        ram_addr   <= sel_addr;
                        ram_we     <= sel_we;
                        ram_wdata  <= sel_wdata;
                        // Writes complete in ACCESS, so their ack is raised now.
                        if (sel_we) begin
                            ack0 <= (pick == MST_CPU);
                            ack1 <= (pick == MST_LOADER);
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_we) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        if (cur_grant == MST_LOADER) begin
                            rdata1 <= ram_rdata;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= ram_rdata;
                            ack0   <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
